// File: rtl/pic_pkg.sv
// pic_pkg: shared types and helpers for the PIC interrupt sequencer.
//   pic_seq_state_t : INTA handshake states (IDLE, ACK1, GAP, ACK2)
//   PIC_NLVL        : number of interrupt levels
//   pic_lowest_set  : lowest-index set bit of an 8-bit vector, plus a valid flag
package pic_pkg;

    localparam int PIC_NLVL = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } pic_seq_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pic_lowest_t;

    // Scans from the top down so the last hit is the lowest index (highest priority).
    function automatic pic_lowest_t pic_lowest_set(input logic [7:0] v);
        pic_lowest_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational fixed-priority winner (IR0 highest).
// Ports:
//   irr   in  8 : pending requests
//   imr   in  8 : mask, 1 masks the level
//   isr   in  8 : levels currently in service
//   lvl   out 3 : index of the highest-priority unmasked request
//   valid out 1 : winner exists and is strictly above every in-service level
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic [2:0] lvl,
    output logic       valid
);

    pic_lowest_t req_low;
    pic_lowest_t isr_low;

    always_comb begin
        req_low = pic_lowest_set(irr & ~imr);
        isr_low = pic_lowest_set(isr);
        lvl     = req_low.idx;
        // Fully nested: a request may only interrupt lower-priority service.
        valid   = req_low.valid && (!isr_low.valid || (req_low.idx < isr_low.idx));
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer: 8259-style interrupt sequencing core.
// Latches IR lines into IRR, resolves fixed priority against IMR/ISR, raises
// intr, runs the two-pulse INTA handshake that drives the vector, and retires
// in-service levels on EOI (specific, non-specific or automatic).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ir[7:0]             : interrupt requests (already synchronous)
//   imr[7:0]            : mask
//   vec_base[4:0]       : vector base (upper five vector bits)
//   ltim, aeoi, init    : level-trigger select, auto-EOI, ICW1 write pulse
//   inta_n              : CPU acknowledge, active-low
//   eoi_cmd/sl/lvl      : EOI pulse, specific select, specific level
//   intr                : interrupt to the CPU
//   dout[7:0], dout_oe  : vector and its bus drive enable
//   irr[7:0], isr[7:0]  : register state for readback
module pic_int_sequencer
    import pic_pkg::*;
#(
    parameter int NLVL = PIC_NLVL
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NLVL-1:0] ir,
    input  logic [NLVL-1:0] imr,
    input  logic [4:0]      vec_base,
    input  logic            ltim,
    input  logic            aeoi,
    input  logic            init,
    input  logic            inta_n,
    input  logic            eoi_cmd,
    input  logic            eoi_sl,
    input  logic [2:0]      eoi_lvl,
    output logic            intr,
    output logic [7:0]      dout,
    output logic            dout_oe,
    output logic [NLVL-1:0] irr,
    output logic [NLVL-1:0] isr
);

    pic_seq_state_t  state;
    pic_seq_state_t  state_nxt;
    logic [NLVL-1:0] ir_q;
    logic [NLVL-1:0] irr_nxt;
    logic [NLVL-1:0] isr_nxt;
    logic [2:0]      lvl;
    logic            spur;
    logic            inta_p0;
    logic            inta_p1;
    logic            inta_fall;
    logic            inta_rise;
    logic [2:0]      win_lvl;
    logic            win_valid;
    logic            do_ack1;
    logic            do_ack2;
    logic            do_done;
    logic            intr_nxt;
    pic_lowest_t     isr_low;

    pic_priority_resolver u_resolver (
        .irr   (irr),
        .imr   (imr),
        .isr   (isr),
        .lvl   (win_lvl),
        .valid (win_valid)
    );

    // inta_p0 samples the pin; inta_p1 is the copy edges are detected against.
    always_ff @(posedge clk) begin
        if (rst) begin
            inta_p0 <= 1'b1;
            inta_p1 <= 1'b1;
        end else begin
            inta_p0 <= inta_n;
            inta_p1 <= inta_p0;
        end
    end

    assign inta_fall = inta_p1 & ~inta_p0;
    assign inta_rise = ~inta_p1 & inta_p0;

    // FSM state register; init aborts a handshake just like rst.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (inta_fall) state_nxt = ST_ACK1;
            ST_ACK1: if (inta_rise) state_nxt = ST_GAP;
            ST_GAP:  if (inta_fall) state_nxt = ST_ACK2;
            ST_ACK2: if (inta_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_ack1  = (state == ST_IDLE) && inta_fall;
        do_ack2  = (state == ST_GAP)  && inta_fall;
        do_done  = (state == ST_ACK2) && inta_rise;
        intr_nxt = (state == ST_IDLE) && win_valid && !do_ack1;
    end

    always_comb begin
        irr_nxt = irr;
        if (ltim) begin
            // Level mode tracks the pins, but holds still once an ack is in progress.
            if (state == ST_IDLE) irr_nxt = ir;
        end else begin
            if (do_ack1 && win_valid) irr_nxt[win_lvl] = 1'b0;
            irr_nxt = irr_nxt | (ir & ~ir_q);
        end
    end

    // Clears are taken from the pre-update isr; the ACK1 set is applied last so it wins.
    always_comb begin
        isr_low = pic_lowest_set(isr);
        isr_nxt = isr;
        if (eoi_cmd) begin
            if (eoi_sl) begin
                isr_nxt[eoi_lvl] = 1'b0;
            end else if (isr_low.valid) begin
                isr_nxt[isr_low.idx] = 1'b0;
            end
        end
        if (do_done && aeoi && !spur) isr_nxt[lvl] = 1'b0;
        if (do_ack1 && win_valid)     isr_nxt[win_lvl] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            ir_q    <= '0;
            irr     <= '0;
            isr     <= '0;
            lvl     <= '0;
            spur    <= 1'b0;
            intr    <= 1'b0;
            dout    <= '0;
            dout_oe <= 1'b0;
        end else begin
            ir_q <= ir;
            irr  <= irr_nxt;
            isr  <= isr_nxt;
            intr <= intr_nxt;
            if (do_ack1) begin
                // No valid winner at the first pulse: answer with level 7.
                lvl  <= win_valid ? win_lvl : 3'd7;
                spur <= !win_valid;
            end
            if (do_ack2) begin
                dout    <= {vec_base, lvl};
                dout_oe <= 1'b1;
            end
            if (do_done) dout_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pic_int_sequencer.sv
module tb_pic_int_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       ltim;
    logic       aeoi;
    logic       init;
    logic       inta_n;
    logic       eoi_cmd;
    logic       eoi_sl;
    logic [2:0] eoi_lvl;
    logic       intr;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    int checks   = 0;
    int failures = 0;

    // Reference state: pending and in-service sets, updated per transaction.
    logic [7:0] m_irr;
    logic [7:0] m_isr;

    pic_int_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .ir       (ir),
        .imr      (imr),
        .vec_base (vec_base),
        .ltim     (ltim),
        .aeoi     (aeoi),
        .init     (init),
        .inta_n   (inta_n),
        .eoi_cmd  (eoi_cmd),
        .eoi_sl   (eoi_sl),
        .eoi_lvl  (eoi_lvl),
        .intr     (intr),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .irr      (irr),
        .isr      (isr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    // Winning level under fixed priority and full nesting, or -1 if none.
    function automatic int winner();
        int w;
        int s;
        w = lowest(m_irr & ~imr);
        s = lowest(m_isr);
        return (w < s) ? w : -1;
    endfunction

    task automatic chk_state(input string tag);
        check({tag, ".irr"},  32'(irr),  32'(m_irr));
        check({tag, ".isr"},  32'(isr),  32'(m_isr));
        check({tag, ".intr"}, 32'(intr), (winner() >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic do_init();
        ir   = 8'h00;
        init = 1'b1;
        tick();
        init  = 1'b0;
        m_irr = 8'h00;
        m_isr = 8'h00;
        tick();
    endtask

    task automatic set_ir(input logic [7:0] v);
        if (ltim) m_irr = v;
        else      m_irr = m_irr | (v & ~ir);
        ir = v;
        tick();
        tick();
    endtask

    task automatic do_eoi(input logic sl, input logic [2:0] l);
        int s;
        if (sl) begin
            m_isr[l] = 1'b0;
        end else begin
            s = lowest(m_isr);
            if (s < 8) m_isr[s] = 1'b0;
        end
        eoi_sl  = sl;
        eoi_lvl = l;
        eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        tick();
        check("eoi.isr", 32'(isr), 32'(m_isr));
    endtask

    // Full two-pulse acknowledge, each phase held three clocks.
    task automatic do_ack(input string tag);
        int w;
        logic [2:0] l;
        w = winner();
        l = (w < 0) ? 3'd7 : 3'(w);
        if (w >= 0) begin
            m_isr[l] = 1'b1;
            if (!ltim) m_irr[l] = 1'b0;
        end
        inta_n = 1'b0;
        tick();
        tick();
        check({tag, ".ack1_intr"}, 32'(intr), 32'd0);
        check({tag, ".ack1_isr"},  32'(isr),  32'(m_isr));
        check({tag, ".ack1_irr"},  32'(irr),  32'(m_irr));
        check({tag, ".ack1_oe"},   32'(dout_oe), 32'd0);
        tick();
        inta_n = 1'b1;
        tick();
        tick();
        tick();
        inta_n = 1'b0;
        tick();
        check({tag, ".ack2_oe_early"}, 32'(dout_oe), 32'd0);
        tick();
        check({tag, ".ack2_oe"},  32'(dout_oe), 32'd1);
        check({tag, ".vector"},   32'(dout), 32'({vec_base, l}));
        tick();
        inta_n = 1'b1;
        tick();
        check({tag, ".oe_hold"},  32'(dout_oe), 32'd1);
        tick();
        if (aeoi && (w >= 0)) m_isr[l] = 1'b0;
        check({tag, ".oe_off"},   32'(dout_oe), 32'd0);
        check({tag, ".done_isr"}, 32'(isr), 32'(m_isr));
        tick();
    endtask

    initial begin
        int a;
        int b;
        int c;
        int r;

        rst      = 1'b1;
        ir       = 8'h00;
        imr      = 8'h00;
        vec_base = 5'b01000;
        ltim     = 1'b0;
        aeoi     = 1'b0;
        init     = 1'b0;
        inta_n   = 1'b1;
        eoi_cmd  = 1'b0;
        eoi_sl   = 1'b0;
        eoi_lvl  = 3'd0;
        m_irr    = 8'h00;
        m_isr    = 8'h00;
        tick();
        tick();
        check("rst.intr",    32'(intr),    32'd0);
        check("rst.dout",    32'(dout),    32'd0);
        check("rst.dout_oe", 32'(dout_oe), 32'd0);
        check("rst.irr",     32'(irr),     32'd0);
        check("rst.isr",     32'(isr),     32'd0);
        rst = 1'b0;
        tick();

        // Basic IR3 ack with base 01000: vector 0x43.
        do_init();
        ir    = 8'h08;
        m_irr = 8'h08;
        tick();
        check("t1.irr_lat",  32'(irr),  32'h08);
        check("t1.intr_lat1", 32'(intr), 32'd0);
        tick();
        check("t1.intr_lat2", 32'(intr), 32'd1);
        do_ack("t1");
        check("t1.isr",  32'(isr),  32'h08);
        check("t1.irr",  32'(irr),  32'h00);
        check("t1.dout", 32'(dout), 32'h43);
        set_ir(8'h00);

        // Nesting: level a in service, requests b < a < c.
        do_init();
        vec_base = 5'($urandom);
        a = int'($urandom_range(2, 6));
        b = int'($urandom_range(0, a - 1));
        c = int'($urandom_range(a + 1, 7));
        set_ir(8'(1 << a));
        do_ack("nest_a");
        set_ir(8'h00);
        set_ir(8'((1 << b) | (1 << c)));
        chk_state("nest_req");
        do_ack("nest_b");
        chk_state("nest_b_done");
        do_eoi(1'b0, 3'd0);
        chk_state("nest_eoi1");
        do_eoi(1'b0, 3'd0);
        chk_state("nest_eoi2");
        do_ack("nest_c");
        set_ir(8'h00);

        // Masking: IR0 masked, IR4 wins; unmask, IR0 wins.
        do_init();
        imr = 8'h01;
        set_ir(8'h11);
        chk_state("mask_req");
        do_ack("mask_l4");
        do_eoi(1'b1, 3'd4);
        imr = 8'h00;
        tick();
        tick();
        chk_state("unmask");
        do_ack("mask_l0");
        check("mask.isr", 32'(isr), 32'h01);
        set_ir(8'h00);

        // Level mode: IR1 withdrawn before INTA -> spurious level 7.
        do_init();
        ltim = 1'b1;
        set_ir(8'h02);
        chk_state("lvl_req");
        set_ir(8'h00);
        chk_state("lvl_drop");
        do_ack("spur");
        check("spur.isr", 32'(isr), 32'h00);
        ltim = 1'b0;

        // Auto-EOI.
        do_init();
        aeoi = 1'b1;
        r = int'($urandom_range(0, 7));
        set_ir(8'(1 << r));
        do_ack("aeoi");
        aeoi = 1'b0;
        set_ir(8'h00);

        // Reset during GAP aborts; the next pulse starts a fresh handshake.
        do_init();
        r = int'($urandom_range(0, 7));
        set_ir(8'(1 << r));
        inta_n = 1'b0;
        tick();
        tick();
        tick();
        inta_n = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("gap_rst.intr",    32'(intr),    32'd0);
        check("gap_rst.dout",    32'(dout),    32'd0);
        check("gap_rst.dout_oe", 32'(dout_oe), 32'd0);
        check("gap_rst.irr",     32'(irr),     32'd0);
        check("gap_rst.isr",     32'(isr),     32'd0);
        m_isr = 8'h00;
        m_irr = ir;
        tick();
        tick();
        chk_state("gap_rst.reedge");
        do_ack("gap_rst.ack");
        set_ir(8'h00);

        // Randomized mix of requests, acks and EOIs in edge mode.
        do_init();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    imr = 8'($urandom) & 8'($urandom);
                    set_ir(8'($urandom));
                end
                1: begin
                    aeoi = 1'($urandom_range(0, 1));
                    do_ack("rnd");
                end
                2: do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
                default: set_ir(8'($urandom));
            endcase
            chk_state("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
